// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-precision adder: one shared 8-bit adder is stepped over
// the latched operands, least significant byte first, with a carry register
// chaining the byte carries. Produces sum, carry-out and a one-cycle done.
// Optional feature macro: SIGNED_OVF_EN adds a registered two's-complement
// overflow output (ovf) that updates together with cout.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
`ifdef SIGNED_OVF_EN
  output logic                  ovf,
`endif
  output logic                  cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic [8:0]    byte_sum;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: the shared 8-bit adder works on the byte selected by idx_q.
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    byte_sum = {1'b0, opa_q[8*idx_q +: 8]} + {1'b0, opb_q[8*idx_q +: 8]} + {8'd0, carry_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[8*idx_q +: 8] = byte_sum[7:0];
        carry_d             = byte_sum[8];
        idx_d               = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = byte_sum[8];
          // Overflow: operands agree in sign but the final sum does not.
          ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (sum_d[W-1] != opa_q[W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SIGNED_OVF_EN
  assign ovf  = ovf_q;
`else
  // Overflow tracking is not exported in this build.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Scoreboard bench for multibyte_add_sequencer: stimulus pushes the expected
// result of a+b+cin (plain wide arithmetic) into a queue, a monitor pops and
// checks whenever done is seen, including done timing and busy release.
module tb_multibyte_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  multibyte_add_sequencer #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SIGNED_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  logic [W-1:0] last_sum;
  logic         last_cout;
  initial begin
    bit prev_done;
    exp_t e;
    prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 0;
        continue;
      end
      if (prev_done) begin
        check("busy_after_done", {{W{1'b0}}, busy}, '0);
        check("done_one_cycle", {{W{1'b0}}, done}, '0);
        check("sum_hold", {cout, sum}, {last_cout, last_sum});
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {{W{1'b0}}, done}, '0);
        end else begin
          e = exp_q.pop_front();
          check("sum", {1'b0, sum}, {1'b0, e.sum});
          check("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, e.cout});
          check("done_cycle", (W+1)'(cyc), (W+1)'(e.done_cyc));
          check("busy_in_done", {{W{1'b0}}, busy}, 1);
`ifdef SIGNED_OVF_EN
          check("ovf", {{W{1'b0}}, ovf}, {{W{1'b0}}, e.ovf});
`endif
          $display("txn: sum=%0h cout=%0b expected sum=%0h cout=%0b at cycle %0d",
                   sum, cout, e.sum, e.cout, cyc);
        end
        last_sum  = sum;
        last_cout = cout;
      end
      prev_done = done;
    end
  end

  // Returns at a falling edge with busy low, or flags a timeout.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", {{W{1'b0}}, busy}, '0);
  endtask

  // Issue one operation; with hold=1 start stays high (and the operands churn)
  // until done is seen.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input bit hold);
    logic [W:0] full;
    exp_t e;
    wait_idle();
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    full = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
    e.sum      = full[W-1:0];
    e.cout     = full[W];
    e.ovf      = (ta[W-1] == tb_v[W-1]) && (full[W-1] != ta[W-1]);
    e.done_cyc = cyc + 1 + NB;
    exp_q.push_back(e);
    @(negedge clk);
    a = rand_word(); b = rand_word(); cin = 1'($urandom);
    if (hold) begin
      for (int i = 0; i < NB + 4; i++) begin
        @(negedge clk);
        a = rand_word(); b = rand_word();
        if (done) break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {{W{1'b0}}, busy}, '0);
    check("reset_done", {{W{1'b0}}, done}, '0);
    check("reset_sum_cout", {cout, sum}, '0);

    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1);
`ifdef SIGNED_OVF_EN
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
`endif

    // Reset after byte 1 has been written: operation must vanish silently.
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check("partial_sum", {1'b0, sum}, {17'd0, 16'h6789});
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("midrst_busy", {{W{1'b0}}, busy}, '0);
    check("midrst_done", {{W{1'b0}}, done}, '0);
    check("midrst_sum_cout", {cout, sum}, '0);
    rst = 1'b0;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 0);

    for (int t = 0; t < 40; t++)
      issue(rand_word(), rand_word(), 1'($urandom), ($urandom_range(0, 7) == 0));

    begin
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", (W+1)'(exp_q.size()), '0);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
